// File: rtl/rle_sched_pkg.sv
// Shared types and constants for the RLE job scheduler: FSM states, job descriptor
// layout and the largest message size the 8-bit engine byte counter can take.
package rle_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_ARM,
    ST_WAIT,
    ST_REPORT
  } sched_state_t;

  typedef struct packed {
    logic [31:0] msg_addr;
    logic [31:0] msg_size;
    logic [31:0] rle_addr;
  } job_desc_t;

  localparam logic [31:0] MAX_MSG_SIZE = 32'd255;

endpackage

// File: rtl/rle_job_fifo.sv
// Job descriptor FIFO for rle_job_sched. Read data shows the head entry combinationally;
// pushes while full and pops while empty are dropped.
module rle_job_fifo
  import rle_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  job_desc_t push_data,
  input  logic      pop,
  output job_desc_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra pointer bit tells full from empty when the index bits match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  job_desc_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/rle_job_sched.sv
// Queues RLE job descriptors and runs them one at a time on the RLE engine.
// Define RLE_SCHED_TIMEOUT_EN to add a watchdog that aborts after TIMEOUT_CYCLES in WAIT.
module rle_job_sched
  import rle_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_msg_addr,
  input  logic [31:0] job_msg_size,
  input  logic [31:0] job_rle_addr,
  output logic        eng_start,
  output logic [31:0] eng_message_addr,
  output logic [31:0] eng_message_size,
  output logic [31:0] eng_rle_addr,
  input  logic        eng_done,
  input  logic [31:0] eng_rle_size,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_size,
  output logic [7:0]  res_tag,
  output logic        res_err,
  output logic        busy,
  output logic [15:0] jobs_done
);

  sched_state_t state;
  job_desc_t    push_desc;
  job_desc_t    head;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic [7:0]   tag_cnt;

  assign push_desc = '{msg_addr: job_msg_addr, msg_size: job_msg_size, rle_addr: job_rle_addr};
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign job_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;

  rle_job_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (job_valid),
    .push_data (push_desc),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef RLE_SCHED_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] wd_cnt;

  // Cleared on the LAUNCH->ARM edge so ARM counts as the first watchdog cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == ST_LAUNCH) begin
      wd_cnt <= '0;
    end else if ((state == ST_ARM) || (state == ST_WAIT)) begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      eng_start        <= 1'b0;
      eng_message_addr <= '0;
      eng_message_size <= '0;
      eng_rle_addr     <= '0;
      res_valid        <= 1'b0;
      res_size         <= '0;
      res_err          <= 1'b0;
      res_tag          <= '0;
      tag_cnt          <= '0;
      jobs_done        <= '0;
    end else begin
      eng_start <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            eng_message_addr <= head.msg_addr;
            eng_message_size <= head.msg_size;
            eng_rle_addr     <= head.rle_addr;
            res_tag          <= tag_cnt;
            tag_cnt          <= tag_cnt + 8'd1;
            // Empty and oversize jobs are reported directly without touching the engine.
            if (head.msg_size == '0) begin
              res_size  <= '0;
              res_err   <= 1'b0;
              res_valid <= 1'b1;
              state     <= ST_REPORT;
            end else if (head.msg_size > MAX_MSG_SIZE) begin
              res_size  <= '0;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
              state     <= ST_REPORT;
            end else begin
              eng_start <= 1'b1;
              state     <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: state <= ST_ARM;
        ST_ARM:    state <= ST_WAIT;
        ST_WAIT: begin
          if (eng_done) begin
            res_size  <= eng_rle_size;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= ST_REPORT;
          end
`ifdef RLE_SCHED_TIMEOUT_EN
          else if (wd_cnt >= WD_LAST) begin
            res_size  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            state     <= ST_REPORT;
          end
`endif
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            jobs_done <= jobs_done + 16'd1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_job_sched.sv
// Directed bench for rle_job_sched; the watchdog case runs when RLE_SCHED_TIMEOUT_EN is defined.
module tb_rle_job_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_msg_addr;
  logic [31:0] job_msg_size;
  logic [31:0] job_rle_addr;
  logic        eng_start;
  logic [31:0] eng_message_addr;
  logic [31:0] eng_message_size;
  logic [31:0] eng_rle_addr;
  logic        eng_done;
  logic [31:0] eng_rle_size;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_size;
  logic [7:0]  res_tag;
  logic        res_err;
  logic        busy;
  logic [15:0] jobs_done;

  int total  = 0;
  int bad    = 0;
  int starts = 0;
  int s0;
  int n;

  rle_job_sched #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_msg_addr     (job_msg_addr),
    .job_msg_size     (job_msg_size),
    .job_rle_addr     (job_rle_addr),
    .eng_start        (eng_start),
    .eng_message_addr (eng_message_addr),
    .eng_message_size (eng_message_size),
    .eng_rle_addr     (eng_rle_addr),
    .eng_done         (eng_done),
    .eng_rle_size     (eng_rle_size),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_size         (res_size),
    .res_tag          (res_tag),
    .res_err          (res_err),
    .busy             (busy),
    .jobs_done        (jobs_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (eng_start === 1'b1) starts++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] s, input logic [31:0] r);
    job_valid    = 1'b1;
    job_msg_addr = a;
    job_msg_size = s;
    job_rle_addr = r;
    step();
    job_valid = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"},     eng_start,        0);
    chk({tag, "_maddr"},     eng_message_addr, 0);
    chk({tag, "_msize"},     eng_message_size, 0);
    chk({tag, "_raddr"},     eng_rle_addr,     0);
    chk({tag, "_rvalid"},    res_valid,        0);
    chk({tag, "_rsize"},     res_size,         0);
    chk({tag, "_rerr"},      res_err,          0);
    chk({tag, "_rtag"},      res_tag,          0);
    chk({tag, "_jobs_done"}, jobs_done,        0);
    chk({tag, "_busy"},      busy,             0);
    chk({tag, "_job_ready"}, job_ready,        1);
  endtask

  initial begin
    reset = 1'b1; job_valid = 1'b0; job_msg_addr = '0; job_msg_size = '0; job_rle_addr = '0;
    eng_done = 1'b0; eng_rle_size = '0; res_ready = 1'b0;

    // Reset values, during and just after reset
    repeat (2) step();
    chk_reset_outputs("rst_in");
    reset = 1'b0;
    step();
    chk_reset_outputs("rst_out");

    // Single job: start two cycles after the push, done 40 cycles after start
    push(32'h0, 32'd12, 32'h100);
    chk("lat_c1_start", eng_start, 0);
    step();
    chk("lat_c2_start", eng_start, 1);
    chk("single_maddr", eng_message_addr, 32'h0);
    chk("single_msize", eng_message_size, 32'd12);
    chk("single_raddr", eng_rle_addr, 32'h100);
    step();
    chk("start_one_cycle", eng_start, 0);
    repeat (39) step();
    chk("single_wait_valid", res_valid, 0);
    chk("single_addr_hold", eng_rle_addr, 32'h100);
    eng_rle_size = 32'd8; eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("single_valid", res_valid, 1);
    chk("single_size", res_size, 8);
    chk("single_tag", res_tag, 0);
    chk("single_err", res_err, 0);
    handshake();
    chk("single_jobs_done", jobs_done, 1);
    chk("single_valid_clr", res_valid, 0);
    chk("single_idle_busy", busy, 0);

    // Job backpressure and result backpressure
    reset = 1'b1; step(); reset = 1'b0; step();
    push(32'h1000, 32'd16, 32'h2000);
    step(); step(); step();
    for (int i = 1; i <= 4; i++) begin
      job_valid = 1'b1; job_msg_addr = 32'(i); job_rle_addr = 32'(i);
      job_msg_size = (i == 1) ? 32'd20 : 32'd0;
      chk("ready_fill", job_ready, 1);
      step();
    end
    job_msg_size = 32'd0;
    chk("ready_full", job_ready, 0);
    s0 = starts;
    eng_rle_size = 32'd5; eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("bp0_valid", res_valid, 1);
    chk("bp0_size", res_size, 5);
    chk("bp0_tag", res_tag, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_valid", res_valid, 1);
      chk("hold_size", res_size, 5);
      chk("hold_tag", res_tag, 0);
      chk("hold_ready", job_ready, 0);
    end
    chk("hold_no_launch", starts, s0);
    handshake();
    chk("bp0_jobs_done", jobs_done, 1);
    chk("ready_still_full", job_ready, 0);
    step();
    chk("bp1_start", eng_start, 1);
    chk("bp1_msize", eng_message_size, 20);
    chk("ready_after_pop", job_ready, 1);
    step();
    job_valid = 1'b0;
    step();
    eng_rle_size = 32'd7; eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("bp1_valid", res_valid, 1);
    chk("bp1_tag", res_tag, 1);
    chk("bp1_size", res_size, 7);
    res_ready = 1'b1;
    for (int t = 2; t <= 5; t++) begin
      step(); step();
      chk("bp_order_valid", res_valid, 1);
      chk("bp_order_tag", res_tag, 32'(t));
      chk("bp_order_size", res_size, 0);
      chk("bp_order_err", res_err, 0);
    end
    step();
    res_ready = 1'b0;
    chk("bp_jobs_done", jobs_done, 6);
    chk("bp_idle_busy", busy, 0);

    // Stale done held through IDLE, LAUNCH and ARM
    eng_rle_size = 32'd9; eng_done = 1'b1;
    push(32'h30, 32'd3, 32'h40);
    step();
    chk("stale_start", eng_start, 1);
    step();
    chk("stale_arm", res_valid, 0);
    step();
    chk("stale_wait", res_valid, 0);
    step();
    chk("stale_report", res_valid, 1);
    chk("stale_size", res_size, 9);
    chk("stale_tag", res_tag, 6);
    eng_done = 1'b0;
    handshake();

    // Size bounds
    s0 = starts;
    push(32'h0, 32'd0, 32'h0);
    step();
    chk("zero_valid", res_valid, 1);
    chk("zero_size", res_size, 0);
    chk("zero_err", res_err, 0);
    chk("zero_tag", res_tag, 7);
    handshake();
    chk("zero_no_start", starts, s0);
    push(32'h0, 32'd300, 32'h0);
    step();
    chk("big_valid", res_valid, 1);
    chk("big_err", res_err, 1);
    chk("big_size", res_size, 0);
    chk("big_tag", res_tag, 8);
    handshake();
    push(32'h0, 32'd256, 32'h0);
    step();
    chk("s256_err", res_err, 1);
    chk("s256_tag", res_tag, 9);
    handshake();
    chk("big_no_start", starts, s0);
    push(32'h0, 32'd255, 32'h0);
    step();
    chk("s255_start", eng_start, 1);
    step(); step();
    eng_rle_size = 32'd1; eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("s255_err", res_err, 0);
    chk("s255_size", res_size, 1);
    chk("s255_tag", res_tag, 10);
    handshake();
    chk("bounds_jobs_done", jobs_done, 11);

    // Reset in WAIT with two jobs queued
    push(32'h50, 32'd4, 32'h60);
    step(); step(); step();
    push(32'h1, 32'd0, 32'h1);
    push(32'h2, 32'd0, 32'h2);
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    step();
    reset = 1'b0;
    repeat (5) step();
    chk("post_rst_valid", res_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_jobs", jobs_done, 0);
    push(32'h0, 32'd0, 32'h0);
    step();
    chk("post_rst_tag", res_tag, 0);
    chk("post_rst_rvalid", res_valid, 1);
    handshake();
    chk("post_rst_done", jobs_done, 1);

`ifdef RLE_SCHED_TIMEOUT_EN
    // Watchdog: no done, result 16 cycles after entering ARM
    push(32'h70, 32'd4, 32'h80);
    step(); step();
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("timeout_cycles", n, 16);
    chk("timeout_err", res_err, 1);
    chk("timeout_size", res_size, 0);
    handshake();
`else
    // No watchdog: WAIT holds until done arrives
    push(32'h70, 32'd4, 32'h80);
    step(); step(); step();
    repeat (40) step();
    chk("no_timeout_valid", res_valid, 0);
    eng_rle_size = 32'd3; eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("late_done_size", res_size, 3);
    chk("late_done_err", res_err, 0);
    handshake();
`endif
    chk("final_jobs_done", jobs_done, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rle_job_sched.md
RLE_JOB_SCHED -- requirements
Module: rle_job_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, job descriptor queue depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, engine watchdog limit (used only under REQ-027).
REQ-003 SHALL have one clock and an asynchronous active-high reset:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
REQ-004 SHALL have these job input ports:
- job_valid  in  1  descriptor offered.
- job_ready  out  1  descriptor accepted when job_valid and job_ready.
- job_msg_addr  in  32  plaintext start address.
- job_msg_size  in  32  plaintext length, bytes.
- job_rle_addr  in  32  output start address.
REQ-005 SHALL have these RLE engine ports:
- eng_start  out  1  one-cycle start pulse.
- eng_message_addr  out  32  held stable from launch until completion.
- eng_message_size  out  32  held stable from launch until completion.
- eng_rle_addr  out  32  held stable from launch until completion.
- eng_done  in  1  level; high while engine is idle with a finished frame.
- eng_rle_size  in  32  compressed length; valid while eng_done is high.
REQ-006 SHALL have these result and status ports:
- res_valid  out  1  result available.
- res_ready  in  1  result consumed when res_valid and res_ready.
- res_size  out  32  rle size.
- res_tag  out  8  job sequence number.
- res_err  out  1  job rejected or aborted.
- busy  out  1  state not IDLE, or queue not empty.
- jobs_done  out  16  completed-result count; wraps modulo 2^16.

Function
REQ-007 SHALL queue descriptors in a FIFO; job_ready = not full, independent of a same-cycle pop.
REQ-008 SHALL run the FSM states IDLE, LAUNCH, ARM, WAIT, REPORT.
REQ-009 IDLE with the queue non-empty SHALL pop the head, latch its fields into the eng_* outputs, and go to LAUNCH next cycle.
REQ-010 LAUNCH SHALL assert eng_start for exactly one cycle and then go to ARM.
REQ-011 ARM SHALL ignore eng_done, lasting one cycle so a stale done from the prior frame is masked, then go to WAIT.
REQ-012 WAIT SHALL, on eng_done=1, capture eng_rle_size into res_size with res_err=0 and go to REPORT.
REQ-013 REPORT SHALL hold res_valid=1 and all res_* outputs stable until res_ready; on the handshake it SHALL increment jobs_done and return to IDLE.
REQ-014 Minimum latency, job push into an empty idle block to eng_start high, SHALL be 2 cycles.
REQ-015 A job with job_msg_size=0 SHALL NOT launch the engine; it SHALL go IDLE->REPORT with res_size=0 and res_err=0.
REQ-016 A job with job_msg_size>255 (engine count is 8 bits) SHALL NOT launch the engine; it SHALL go IDLE->REPORT with res_size=0 and res_err=1.
REQ-017 res_tag SHALL be an 8-bit counter, incremented on every pop and wrapping 255->0; the first job after reset SHALL carry tag 0.
REQ-018 The FIFO SHALL handle a simultaneous push and pop when non-full: occupancy unchanged, order preserved.
REQ-019 An engine done arriving in IDLE, LAUNCH or REPORT SHALL be ignored.

Reset
REQ-020 Reset SHALL asynchronously force state IDLE and empty the FIFO.
REQ-021 During and immediately after reset, outputs SHALL be:
- eng_start=0.
- eng_* addresses and sizes = 0.
- res_valid=0, res_size=0, res_err=0, res_tag=0.
- jobs_done=0, busy=0.
- job_ready=1.
REQ-022 Reset mid-job SHALL discard the in-flight job and all queued jobs with no result reported.

Configuration
REQ-023 Macro RLE_SCHED_TIMEOUT_EN SHALL select the watchdog behaviour (REQ-024, REQ-025).
REQ-024 With RLE_SCHED_TIMEOUT_EN defined, a cycle counter SHALL clear on entering ARM.
REQ-025 With RLE_SCHED_TIMEOUT_EN defined, if WAIT reaches TIMEOUT_CYCLES without eng_done, the block SHALL go to REPORT with res_size=0 and res_err=1.
REQ-026 Without RLE_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely, and no counter logic SHALL exist.
REQ-027 TIMEOUT_CYCLES SHALL be ignored when RLE_SCHED_TIMEOUT_EN is undefined.

Structure
REQ-028 Package rle_sched_pkg SHALL hold:
- the FSM state enum.
- the job descriptor struct typedef (msg_addr, msg_size, rle_addr).
- constant MAX_MSG_SIZE=255.
REQ-029 Sub-module rle_job_fifo SHALL implement the descriptor FIFO (push/pop/full/empty); the FSM stays in the top.

Verification
REQ-030 The bench SHALL cover the single-job case: push {0x00,12,0x100}; model asserts done 40 cycles after start with size 8 -> eng_start at cycle 2, res_valid with res_size=8, res_tag=0, res_err=0, jobs_done=1.
REQ-031 The bench SHALL cover backpressure: push 5 jobs back-to-back with FIFO_DEPTH=4 while busy -> job_ready low on the 5th until a pop; tags 0..4 are reported in order.
REQ-032 The bench SHALL cover stale done: hold eng_done=1 continuously through launch -> no completion is taken in ARM; completion is taken in WAIT.
REQ-033 The bench SHALL cover the size bounds:
- job_msg_size=0 -> no eng_start, res_size=0, res_err=0.
- job_msg_size=300 -> no eng_start, res_err=1.
REQ-034 The bench SHALL cover backpressure on results: res_ready held low 10 cycles -> res_* stable, next job not launched.
REQ-035 The bench SHALL cover reset and timeout:
- reset pulsed in WAIT with 2 queued -> all outputs at reset values, job_ready=1.
- With RLE_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, done never arrives -> res_err=1 16 cycles after ARM.
